// File: rtl/synth_seq_pkg.sv
// Shared types and constant helpers for the oscillator slot sequencer.
// The slot index struct describes the default {vx,ox,oe} packing of the xxxx bus.
package synth_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} seq_state_e;

    localparam int DEF_V_WIDTH  = 3;
    localparam int DEF_O_WIDTH  = 2;
    localparam int DEF_OE_WIDTH = 1;

    typedef struct packed {
        logic [DEF_V_WIDTH-1:0]  vx;
        logic [DEF_O_WIDTH-1:0]  ox;
        logic [DEF_OE_WIDTH-1:0] oe;
    } slot_idx_t;

    function automatic int e_width(input int o_width, input int oe_width);
        return o_width + oe_width;
    endfunction

    function automatic int slots(input int voices, input int e_w);
        return voices << e_w;
    endfunction

endpackage

// File: rtl/seq_phase_reset_tracker.sv
// Per-voice phase-reset request: raised when the voice leaves the free state,
// dropped once the voice's last slot has been issued in a frame started afterwards.
module seq_phase_reset_tracker
    import synth_seq_pkg::*;
#(
    parameter int                 S_WIDTH   = 6,
    parameter logic [S_WIDTH-1:0] LAST_SLOT = '1
) (
    input  logic               OSC_CLK,
    input  logic               reset,
    input  logic               voice_free,
    input  logic               frame_start,
    input  logic               slot_stb,
    input  logic [S_WIDTH-1:0] slot_idx,
    output logic               phase_reset
);

    logic free_q, free_d;
    logic pend_q, pend_d;
    logic armed_q, armed_d;
    logic fall;
    logic clear_hit;

    assign fall      = free_q && !voice_free;
    assign clear_hit = armed_q && slot_stb && (slot_idx == LAST_SLOT);

    // Only a frame that begins while the request is already pending may retire it.
    always_comb begin
        free_d  = voice_free;
        pend_d  = pend_q;
        armed_d = armed_q;
        if (fall) begin
            pend_d  = 1'b1;
            armed_d = 1'b0;
        end else if (voice_free || clear_hit) begin
            pend_d  = 1'b0;
            armed_d = 1'b0;
        end else if (frame_start && pend_q) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge OSC_CLK or posedge reset) begin
        if (reset) begin
            free_q  <= 1'b0;
            pend_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            free_q  <= free_d;
            pend_q  <= pend_d;
            armed_q <= armed_d;
        end
    end

    assign phase_reset = pend_q && !voice_free;

endmodule

// File: rtl/osc_slot_sequencer.sv
// Frame scheduler walking every voice/osc/env slot once per sample tick.
// Optional macro SEQ_SKIP_FREE_VOICES_EN skips voices that were free at the tick.
module osc_slot_sequencer
    import synth_seq_pkg::*;
#(
    parameter int VOICES   = 8,
    parameter int V_WIDTH  = 3,
    parameter int O_WIDTH  = 2,
    parameter int OE_WIDTH = 1,
    parameter int CLK_DIV  = 4,
    parameter int PIPE_LAT = 3
) (
    input  logic                                 OSC_CLK,
    input  logic                                 reset,
    input  logic                                 sample_tick,
    input  logic [VOICES-1:0]                    voice_free,
    output logic [V_WIDTH+O_WIDTH+OE_WIDTH-1:0]  xxxx,
    output logic                                 slot_stb,
    output logic [VOICES-1:0]                    phase_reset,
    output logic                                 frame_busy,
    output logic                                 frame_done,
    output logic                                 overrun,
    input  logic                                 overrun_clr
);

    localparam int E_WIDTH   = e_width(O_WIDTH, OE_WIDTH);
    localparam int S_WIDTH   = V_WIDTH + E_WIDTH;
    localparam int DIV_W     = $clog2(CLK_DIV);
    localparam int DRAIN_CYC = PIPE_LAT * CLK_DIV;
    localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

    seq_state_e         state_q, state_d;
    logic [S_WIDTH-1:0] slot_q, slot_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               done_q, done_d;
    logic               overrun_q, overrun_d;
    logic               frame_start;

    assign frame_start = (state_q == IDLE) && sample_tick;

`ifdef SEQ_SKIP_FREE_VOICES_EN
    localparam logic [E_WIDTH-1:0] E_LAST = '1;

    logic [VOICES-1:0]  snap_q, snap_d;
    logic [VOICES-1:0]  search_free;
    int                 search_from;
    logic               next_found;
    logic [V_WIDTH-1:0] next_vx;

    // Lowest busy voice at or above search_from; the tick edge uses the live inputs
    // because the snapshot is being captured on that same edge.
    always_comb begin
        search_free = (state_q == IDLE) ? voice_free : snap_q;
        search_from = (state_q == IDLE) ? 0 : int'(slot_q[S_WIDTH-1:E_WIDTH]) + 1;
        next_found  = 1'b0;
        next_vx     = '0;
        for (int v = VOICES - 1; v >= 0; v--) begin
            if (v >= search_from && !search_free[v]) begin
                next_found = 1'b1;
                next_vx    = V_WIDTH'(v);
            end
        end
    end

    assign snap_d = (state_q == IDLE) ? voice_free : snap_q;

    always_ff @(posedge OSC_CLK or posedge reset) begin
        if (reset) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end
`else
    localparam int                 SLOTS     = slots(VOICES, E_WIDTH);
    localparam logic [S_WIDTH-1:0] SLOT_LAST = S_WIDTH'(SLOTS - 1);
`endif

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        div_d     = div_q;
        drain_d   = drain_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;

        // A dropped tick outranks a simultaneous clear.
        if (sample_tick && state_q != IDLE) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                slot_d  = '0;
                div_d   = '0;
                drain_d = '0;
                if (sample_tick) begin
`ifdef SEQ_SKIP_FREE_VOICES_EN
                    if (next_found) begin
                        state_d = RUN;
                        slot_d  = {next_vx, {E_WIDTH{1'b0}}};
                    end else begin
                        state_d = DRAIN;
                    end
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
                if (div_q == DIV_LAST) begin
`ifdef SEQ_SKIP_FREE_VOICES_EN
                    if (slot_q[E_WIDTH-1:0] != E_LAST) begin
                        slot_d = slot_q + 1'b1;
                    end else if (next_found) begin
                        slot_d = {next_vx, {E_WIDTH{1'b0}}};
                    end else begin
                        state_d = DRAIN;
                    end
`else
                    if (slot_q == SLOT_LAST) begin
                        state_d = DRAIN;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
`endif
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = IDLE;
                    drain_d = '0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge OSC_CLK or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            div_q     <= '0;
            drain_q   <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            div_q     <= div_d;
            drain_q   <= drain_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign xxxx       = slot_q;
    assign slot_stb   = (state_q == RUN) && (div_q == '0);
    assign frame_busy = (state_q != IDLE);
    assign frame_done = done_q;
    assign overrun    = overrun_q;

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        localparam logic [S_WIDTH-1:0] LAST_SLOT = {V_WIDTH'(v), {E_WIDTH{1'b1}}};

        seq_phase_reset_tracker #(
            .S_WIDTH   (S_WIDTH),
            .LAST_SLOT (LAST_SLOT)
        ) u_tracker (
            .OSC_CLK     (OSC_CLK),
            .reset       (reset),
            .voice_free  (voice_free[v]),
            .frame_start (frame_start),
            .slot_stb    (slot_stb),
            .slot_idx    (slot_q),
            .phase_reset (phase_reset[v])
        );
    end

endmodule

// File: tb/tb_osc_slot_sequencer.sv
// Directed self-checking bench for osc_slot_sequencer with default parameters.
// Scenarios for SEQ_SKIP_FREE_VOICES_EN are compiled in when that macro is defined.
module tb_osc_slot_sequencer;
    import synth_seq_pkg::*;

    localparam int TIMEOUT = 400;

    logic       OSC_CLK = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic [7:0] voice_free;
    logic       overrun_clr;
    logic [5:0] xxxx;
    logic       slot_stb;
    logic [7:0] phase_reset;
    logic       frame_busy;
    logic       frame_done;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    osc_slot_sequencer dut (
        .OSC_CLK     (OSC_CLK),
        .reset       (reset),
        .sample_tick (sample_tick),
        .voice_free  (voice_free),
        .xxxx        (xxxx),
        .slot_stb    (slot_stb),
        .phase_reset (phase_reset),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 OSC_CLK = ~OSC_CLK;

    task automatic step();
        @(posedge OSC_CLK);
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        sample_tick = 1'b0;
        voice_free  = 8'h00;
        overrun_clr = 1'b0;
        step();
        step();
        total += 6;
        if (xxxx !== 6'd0) begin bad++; $display("[TB] FAIL reset_xxxx got=%0d want=0", xxxx); end
        if (slot_stb !== 1'b0) begin bad++; $display("[TB] FAIL reset_stb got=%b want=0", slot_stb); end
        if (phase_reset !== 8'h00) begin bad++; $display("[TB] FAIL reset_phase got=%h want=00", phase_reset); end
        if (frame_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", frame_busy); end
        if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", frame_done); end
        if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun got=%b want=0", overrun); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_frame();
        int   n;
        int   strobes;
        int   done_at;
        logic exp_stb;
        logic exp_busy;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        n = 1;
        strobes = 0;
        done_at = 0;
        while (done_at == 0 && n <= TIMEOUT) begin
            exp_stb  = (n <= 256) && ((n - 1) % 4 == 0);
            exp_busy = (n < 269);
            total++;
            if (slot_stb !== exp_stb) begin
                bad++; $display("[TB] FAIL frame_stb n=%0d got=%b want=%b", n, slot_stb, exp_stb);
            end
            total++;
            if (frame_busy !== exp_busy) begin
                bad++; $display("[TB] FAIL frame_busy n=%0d got=%b want=%b", n, frame_busy, exp_busy);
            end
            if (slot_stb === 1'b1) begin
                total++;
                if (xxxx !== 6'(strobes)) begin
                    bad++; $display("[TB] FAIL frame_xxxx n=%0d got=%0d want=%0d", n, xxxx, strobes);
                end
                strobes++;
            end
            if (frame_done === 1'b1) done_at = n;
            else begin step(); n++; end
        end
        total += 2;
        if (done_at != 269) begin bad++; $display("[TB] FAIL frame_latency got=%0d want=269", done_at); end
        if (strobes != 64) begin bad++; $display("[TB] FAIL frame_strobes got=%0d want=64", strobes); end
        step();
        total++;
        if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL frame_done_width got=%b want=0", frame_done); end
    endtask

    task automatic test_overrun();
        int n;
        int done_at;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        n = 1;
        while (n < 10) begin step(); n++; end
        sample_tick = 1'b1;
        step();
        n++;
        sample_tick = 1'b0;
        total++;
        if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL overrun_set got=%b want=1", overrun); end
        done_at = 0;
        while (done_at == 0 && n <= TIMEOUT) begin
            if (frame_done === 1'b1) done_at = n;
            else begin step(); n++; end
        end
        total++;
        if (done_at != 269) begin bad++; $display("[TB] FAIL overrun_latency got=%0d want=269", done_at); end
        step();
    endtask

    task automatic test_overrun_clr();
        int n;
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        total++;
        if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL clr_alone got=%b want=0", overrun); end
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        sample_tick = 1'b1;
        overrun_clr = 1'b1;
        step();
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        total++;
        if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL clr_vs_tick got=%b want=1", overrun); end
        n = 0;
        while (frame_done !== 1'b1 && n < TIMEOUT) begin step(); n++; end
        total++;
        if (frame_done !== 1'b1) begin bad++; $display("[TB] FAIL clr_frame_end got=%b want=1", frame_done); end
        step();
    endtask

    task automatic test_phase_reset();
        slot_idx_t last5;
        int        clear_n;
        int        n;
        logic [7:0] exp_pr;
        last5   = '{vx: 3'd5, ox: 2'b11, oe: 1'b1};
        clear_n = int'(last5) * 4 + 2;
        voice_free = 8'h20;
        step();
        step();
        total++;
        if (phase_reset !== 8'h00) begin bad++; $display("[TB] FAIL pr_rise got=%h want=00", phase_reset); end
        voice_free = 8'h00;
        step();
        total++;
        if (phase_reset !== 8'h20) begin bad++; $display("[TB] FAIL pr_set got=%h want=20", phase_reset); end
        step();
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        n = 1;
        while (frame_done !== 1'b1 && n <= TIMEOUT) begin
            exp_pr = (n < clear_n) ? 8'h20 : 8'h00;
            total++;
            if (phase_reset !== exp_pr) begin
                bad++; $display("[TB] FAIL pr_frame n=%0d got=%h want=%h", n, phase_reset, exp_pr);
            end
            step();
            n++;
        end
        total++;
        if (frame_done !== 1'b1) begin bad++; $display("[TB] FAIL pr_frame_end got=%b want=1", frame_done); end
        step();
    endtask

    task automatic test_free_rise_clear();
        voice_free = 8'h04;
        step();
        voice_free = 8'h00;
        step();
        total++;
        if (phase_reset !== 8'h04) begin bad++; $display("[TB] FAIL rise_set got=%h want=04", phase_reset); end
        voice_free = 8'h04;
        #1;
        total++;
        if (phase_reset !== 8'h00) begin bad++; $display("[TB] FAIL rise_immediate got=%h want=00", phase_reset); end
        step();
        total++;
        if (phase_reset !== 8'h00) begin bad++; $display("[TB] FAIL rise_held got=%h want=00", phase_reset); end
        voice_free = 8'h00;
        step();
        total++;
        if (phase_reset !== 8'h04) begin bad++; $display("[TB] FAIL rise_reset got=%h want=04", phase_reset); end
    endtask

`ifdef SEQ_SKIP_FREE_VOICES_EN
    task automatic test_skip_free();
        int   n;
        int   done_at;
        logic exp_stb;
        voice_free = 8'hFE;
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        n = 1;
        done_at = 0;
        while (done_at == 0 && n <= TIMEOUT) begin
            exp_stb = (n <= 29) && ((n - 1) % 4 == 0);
            total++;
            if (slot_stb !== exp_stb) begin
                bad++; $display("[TB] FAIL skip_stb n=%0d got=%b want=%b", n, slot_stb, exp_stb);
            end
            if (slot_stb === 1'b1) begin
                total++;
                if (xxxx !== 6'((n - 1) / 4)) begin
                    bad++; $display("[TB] FAIL skip_xxxx n=%0d got=%0d want=%0d", n, xxxx, (n - 1) / 4);
                end
            end
            if (frame_done === 1'b1) done_at = n;
            else begin step(); n++; end
        end
        total++;
        if (done_at != 45) begin bad++; $display("[TB] FAIL skip_latency got=%0d want=45", done_at); end
        step();
        voice_free = 8'hFF;
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        n = 1;
        done_at = 0;
        while (done_at == 0 && n <= TIMEOUT) begin
            total++;
            if (slot_stb !== 1'b0) begin bad++; $display("[TB] FAIL allfree_stb n=%0d got=%b want=0", n, slot_stb); end
            if (frame_done === 1'b1) done_at = n;
            else begin step(); n++; end
        end
        total++;
        if (done_at != 13) begin bad++; $display("[TB] FAIL allfree_latency got=%0d want=13", done_at); end
        step();
        voice_free = 8'h00;
        step();
    endtask
`endif

    task automatic test_reset_mid_frame();
        int n;
        int done_seen;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        n = 1;
        while (!(slot_stb === 1'b1 && xxxx === 6'd20) && n < TIMEOUT) begin step(); n++; end
        total++;
        if (n != 81) begin bad++; $display("[TB] FAIL mid_slot20_at got=%0d want=81", n); end
        reset = 1'b1;
        #1;
        total += 6;
        if (xxxx !== 6'd0) begin bad++; $display("[TB] FAIL mid_xxxx got=%0d want=0", xxxx); end
        if (slot_stb !== 1'b0) begin bad++; $display("[TB] FAIL mid_stb got=%b want=0", slot_stb); end
        if (frame_busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy got=%b want=0", frame_busy); end
        if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL mid_done got=%b want=0", frame_done); end
        if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL mid_overrun got=%b want=0", overrun); end
        if (phase_reset !== 8'h00) begin bad++; $display("[TB] FAIL mid_phase got=%h want=00", phase_reset); end
        step();
        step();
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (frame_done === 1'b1) done_seen++;
        end
        total++;
        if (done_seen != 0) begin bad++; $display("[TB] FAIL mid_no_done got=%0d want=0", done_seen); end
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        total += 2;
        if (slot_stb !== 1'b1) begin bad++; $display("[TB] FAIL restart_stb got=%b want=1", slot_stb); end
        if (xxxx !== 6'd0) begin bad++; $display("[TB] FAIL restart_xxxx got=%0d want=0", xxxx); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overrun();
        test_overrun_clr();
        test_phase_reset();
        test_free_rise_clear();
`ifdef SEQ_SKIP_FREE_VOICES_EN
        test_skip_free();
`endif
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
